// File: rtl/bram_writer_in.sv
// bram_writer_in: writes a valid/ready pixel stream, one frame at a time and in
// raster order, into one half of a ping-pong frame BRAM. Once a frame is full
// and the downstream reader is idle, it hands the buffer off with a one-cycle
// start pulse and then fills the other half.
module bram_writer_in #(
  parameter  int WIDTH      = 120,
  parameter  int HEIGHT     = 240,
  parameter  int DATA_WIDTH = 21,
  localparam int FRAME_SIZE = WIDTH * HEIGHT,
  localparam int ADDR_BITS  = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sof,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_bram_index,
  output logic [ADDR_BITS-1:0]  wr_address,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  output logic                  reader_start,
  output logic                  reader_bram_index,
  input  logic                  reader_idle,
  output logic [15:0]           frames_written,
  output logic [7:0]            sof_errors
);

  typedef enum logic [1:0] {
    ST_WAIT_SOF = 2'd0,
    ST_WRITING  = 2'd1,
    ST_HANDOFF  = 2'd2
  } state_t;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FRAME_SIZE - 1);
  localparam logic [ADDR_BITS-1:0] ONE_ADDR  = ADDR_BITS'(1);

  state_t                  state_q;
  logic [ADDR_BITS-1:0]    cnt_q;
  logic [ADDR_BITS-1:0]    cnt_d;
  logic                    wr_en_q;
  logic [ADDR_BITS-1:0]    wr_addr_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic                    wr_idx_q;
  logic                    start_q;
  logic                    ridx_q;
  logic                    guard_q;
  logic [15:0]             frames_q;
  logic [7:0]              sof_err_q;
  logic                    accept;

  // Backpressure only while a full frame waits for the reader.
  assign in_ready = (state_q != ST_HANDOFF);
  assign accept   = in_valid && in_ready;
  assign cnt_d    = cnt_q + ONE_ADDR;

  assign wr_en             = wr_en_q;
  assign wr_address        = wr_addr_q;
  assign wr_data           = wr_data_q;
  assign wr_bram_index     = wr_idx_q;
  assign reader_start      = start_q;
  assign reader_bram_index = ridx_q;
  assign frames_written    = frames_q;
  assign sof_errors        = sof_err_q;

  // Frame-capture FSM with registered write port, handoff pulse and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_WAIT_SOF;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_idx_q  <= 1'b0;
      start_q   <= 1'b0;
      ridx_q    <= 1'b0;
      guard_q   <= 1'b0;
      frames_q  <= 16'd0;
      sof_err_q <= 8'd0;
    end else begin
      wr_en_q <= 1'b0;
      start_q <= 1'b0;
      // The reader drops reader_idle one cycle late; hide that cycle.
      guard_q <= start_q;
      case (state_q)
        ST_WAIT_SOF: begin
          if (accept && in_sof) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= in_data;
            cnt_q     <= ONE_ADDR;
            state_q   <= (FRAME_SIZE == 1) ? ST_HANDOFF : ST_WRITING;
          end
        end
        ST_WRITING: begin
          if (accept) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= in_data;
            if (in_sof) begin
              // Early SOF: drop the partial frame and restart at address 0.
              wr_addr_q <= '0;
              cnt_q     <= ONE_ADDR;
              if (sof_err_q != 8'hFF) begin
                sof_err_q <= sof_err_q + 8'd1;
              end
            end else begin
              wr_addr_q <= cnt_q;
              cnt_q     <= cnt_d;
              if (cnt_q == LAST_ADDR) begin
                state_q <= ST_HANDOFF;
              end
            end
          end
        end
        ST_HANDOFF: begin
          // The first HANDOFF cycle carries the last write, so the pulse
          // registered here always lands at least one cycle after it.
          if (reader_idle && !guard_q) begin
            start_q  <= 1'b1;
            ridx_q   <= wr_idx_q;
            wr_idx_q <= ~wr_idx_q;
            frames_q <= frames_q + 16'd1;
            cnt_q    <= '0;
            state_q  <= ST_WAIT_SOF;
          end
        end
        default: begin
          state_q <= ST_WAIT_SOF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_writer_in.sv
// Bench for bram_writer_in with a 4x2 frame: a frame-level model predicts the
// outputs every cycle, a BRAM image built from the write port is compared to
// the expected frame on every handoff, and directed scenarios add literal checks.
module tb_bram_writer_in;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int AB = 3;
  localparam int DW = 21;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_sof;
  logic          in_valid;
  logic          in_ready;
  logic          wr_bram_index;
  logic [AB-1:0] wr_address;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          reader_start;
  logic          reader_bram_index;
  logic          reader_idle;
  logic [15:0]   frames_written;
  logic [7:0]    sof_errors;

  always #5 clk = ~clk;

  bram_writer_in #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sof(in_sof),
    .in_valid(in_valid), .in_ready(in_ready), .wr_bram_index(wr_bram_index),
    .wr_address(wr_address), .wr_data(wr_data), .wr_en(wr_en),
    .reader_start(reader_start), .reader_bram_index(reader_bram_index),
    .reader_idle(reader_idle), .frames_written(frames_written),
    .sof_errors(sof_errors)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  bit            mv = 1'b0;
  bit            e_wr_en, e_start, e_idx, e_ridx;
  logic [AB-1:0] e_addr;
  logic [DW-1:0] e_data;
  int            e_frames, e_sof;
  int            pos;        // -1: waiting for SOF, else next raster position
  bit            full;       // complete frame waiting to be handed off
  int            since;      // cycles since the last reader_start pulse
  logic [DW-1:0] frame_q[$];
  logic [DW-1:0] last_frame[N];

  // image of the BRAM as written by the DUT
  logic [DW-1:0] mem[2][N];
  int            n_starts = 0;
  int            n_wr     = 0;

  // compare current outputs, then advance the model with this cycle's inputs
  always @(negedge clk) begin
    if (mv) begin
      chk("in_ready", in_ready, !full);
      chk("wr_en", wr_en, e_wr_en);
      if (e_wr_en) begin
        chk("wr_address", wr_address, e_addr);
        chk("wr_data", wr_data, e_data);
      end
      chk("wr_bram_index", wr_bram_index, e_idx);
      chk("reader_start", reader_start, e_start);
      chk("reader_bram_index", reader_bram_index, e_ridx);
      chk("frames_written", frames_written, e_frames[15:0]);
      chk("sof_errors", sof_errors, e_sof[7:0]);
      if (reader_start === 1'b1 && reader_bram_index !== 1'bx) begin
        n_starts++;
        for (int i = 0; i < N; i++) begin
          chk("frame_content", mem[reader_bram_index][i], last_frame[i]);
        end
      end
      if (wr_en === 1'b1) begin
        mem[wr_bram_index][wr_address] = wr_data;
        n_wr++;
      end
    end
    if (reset === 1'b1) begin
      mv = 1'b1;
      e_wr_en = 1'b0; e_addr = '0; e_data = '0; e_idx = 1'b0;
      e_start = 1'b0; e_ridx = 1'b0; e_frames = 0; e_sof = 0;
      pos = -1; full = 1'b0; since = 100;
      frame_q.delete();
    end else if (mv) begin
      if (e_start) since = 0; else since++;
      e_wr_en = 1'b0;
      e_start = 1'b0;
      if (in_valid && !full) begin
        if (in_sof) begin
          if (pos >= 1 && e_sof < 255) e_sof++;
          e_wr_en = 1'b1; e_addr = '0; e_data = in_data;
          frame_q.delete();
          frame_q.push_back(in_data);
          pos = 1;
        end else if (pos >= 1) begin
          e_wr_en = 1'b1; e_addr = AB'(pos); e_data = in_data;
          frame_q.push_back(in_data);
          pos++;
        end
        if (pos == N) begin
          full = 1'b1;
          for (int i = 0; i < N; i++) last_frame[i] = frame_q[i];
        end
      end else if (full && reader_idle && since >= 2) begin
        e_start = 1'b1; e_ridx = e_idx; e_idx = ~e_idx;
        e_frames = (e_frames + 1) % 65536;
        full = 1'b0; pos = -1;
      end
    end
  end

  // ---------------- reader emulation ----------------
  bit reader_emu = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (reader_emu && reader_start === 1'b1) begin
        @(posedge clk); #1;
        reader_idle = 1'b0;
        repeat ($urandom_range(0, 12)) begin
          @(posedge clk); #1;
        end
        reader_idle = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit sof);
    int k   = 0;
    bit acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_sof = sof;
    while (!acc && k < 300) begin
      @(negedge clk);
      acc = (in_ready === 1'b1);
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0; in_sof = 1'b0;
    if (!acc) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: beat %0h not accepted within 300 cycles", d);
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send(base + DW'(i), i == 0);
    end
  endtask

  task automatic wait_starts(input int target, input int budget);
    int k = 0;
    while (n_starts < target && k < budget) begin
      tick();
      k++;
    end
    chk("start_count", n_starts, target);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int s;
    int s_wr;
    in_valid = 1'b0; in_sof = 1'b0; in_data = '0; reader_idle = 1'b1;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // reset state
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_address", wr_address, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_bram_index", wr_bram_index, 0);
    chk("rst_reader_start", reader_start, 0);
    chk("rst_frames", frames_written, 0);
    chk("rst_sof_errors", sof_errors, 0);

    // frame 1: data 1..8 into buffer 0
    send_frame(21'd1, 1'b0);
    wait_starts(1, 50);
    chk("f1_frames", frames_written, 1);
    chk("f1_wr_idx", wr_bram_index, 1);
    chk("f1_reader_idx", reader_bram_index, 0);
    for (int i = 0; i < N; i++) chk("f1_mem", mem[0][i], i + 1);

    // frame 2 with the reader busy for 20 cycles
    reader_idle = 1'b0;
    send_frame(21'd11, 1'b0);
    s = n_starts;
    repeat (20) begin
      tick();
      chk("busy_in_ready", in_ready, 0);
    end
    chk("busy_no_start", n_starts, s);
    reader_idle = 1'b1;
    wait_starts(2, 20);
    chk("f2_reader_idx", reader_bram_index, 1);
    chk("f2_frames", frames_written, 2);
    chk("f2_wr_idx", wr_bram_index, 0);

    // frame 3 goes back to buffer 0
    send_frame(21'd21, 1'b0);
    wait_starts(3, 50);
    chk("f3_reader_idx", reader_bram_index, 0);
    for (int i = 0; i < N; i++) chk("f3_mem", mem[0][i], 21 + i);

    // non-SOF beats before SOF are discarded
    s_wr = n_wr;
    send(21'd99, 1'b0); send(21'd98, 1'b0); send(21'd97, 1'b0);
    tick();
    chk("pre_sof_no_write", n_wr, s_wr);
    send_frame(21'd31, 1'b0);
    wait_starts(4, 50);
    chk("f4_write_count", n_wr - s_wr, 8);
    chk("f4_mem0", mem[1][0], 31);

    // early SOF after 5 beats
    send(21'd41, 1'b1);
    for (int i = 1; i < 5; i++) send(21'd41 + DW'(i), 1'b0);
    send(21'd51, 1'b1);
    for (int i = 1; i < 7; i++) send(21'd51 + DW'(i), 1'b0);
    tick(); tick();
    chk("esof_no_start_yet", n_starts, 4);
    chk("esof_count", sof_errors, 1);
    send(21'd58, 1'b0);
    wait_starts(5, 50);
    chk("esof_reader_idx", reader_bram_index, 0);
    for (int i = 0; i < N; i++) chk("esof_mem", mem[0][i], 51 + i);

    // reset mid-frame after the beat at address 4
    for (int i = 0; i < 5; i++) send(21'd61 + DW'(i), i == 0);
    s = n_starts;
    pulse_reset();
    chk("mrst_wr_en", wr_en, 0);
    chk("mrst_wr_address", wr_address, 0);
    chk("mrst_frames", frames_written, 0);
    chk("mrst_sof_errors", sof_errors, 0);
    chk("mrst_wr_idx", wr_bram_index, 0);
    repeat (5) tick();
    chk("mrst_no_start", n_starts, s);
    send_frame(21'd71, 1'b0);
    wait_starts(s + 1, 50);
    chk("mrst_reader_idx", reader_bram_index, 0);
    chk("mrst_frames_after", frames_written, 1);
    for (int i = 0; i < N; i++) chk("mrst_mem", mem[0][i], 71 + i);

    // 300 frames with random gaps and a lagging, randomly busy reader
    pulse_reset();
    s = n_starts;
    reader_emu = 1'b1;
    for (int f = 0; f < 300; f++) begin
      send_frame(DW'($urandom_range(0, 1 << 20)), 1'b1);
    end
    wait_starts(s + 300, 200);
    chk("soak_frames", frames_written, 300);
    reader_emu = 1'b0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bram_writer_in.md
Name: bram_writer_in

Overview:
- Upstream neighbour of the output BRAM reader in the disparity-filtering path.
- Accepts a valid/ready pixel stream with start-of-frame marking and writes each frame, in raster order, into one half of a ping-pong frame BRAM.
- When a frame is complete and the reader is idle, pulses the reader's start with the index of the just-filled buffer, then fills the other buffer.

Parameters:
- width, 120, pixels per row
- height, 240, rows per frame
- frame_size, width*height, words per frame/buffer
- addr_bits, $clog2(frame_size), BRAM address width
- data_width, 21, pixel word width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_data  in  data_width  pixel word
- in_sof  in  1  marks first pixel of a frame; qualified by in_valid
- in_valid  in  1  in_data/in_sof valid
- in_ready  out  1  block accepts a beat this cycle
- wr_bram_index  out  1  buffer currently being written
- wr_address  out  addr_bits  BRAM write address
- wr_data  out  data_width  BRAM write data
- wr_en  out  1  BRAM write strobe
- reader_start  out  1  one-cycle start pulse to reader
- reader_bram_index  out  1  buffer index presented with reader_start
- reader_idle  in  1  reader is idle
- frames_written  out  16  completed frames handed off, wraps
- sof_errors  out  8  early-SOF count, saturates at 255

Behaviour:
- Beat accepted when in_valid && in_ready.
- Reset (synchronous, active-high; also mid-frame): state=ST_WAIT_SOF; in_ready=1; wr_en=0; wr_address=0; wr_data=0; wr_bram_index=0; reader_start=0; reader_bram_index=0; frames_written=0; sof_errors=0; pixel counter=0; start_guard=0. A partial frame in progress is abandoned and no start is issued.
- ST_WAIT_SOF: in_ready=1. Beats with in_sof=0 are accepted and discarded (no wr_en). A beat with in_sof=1 is written to address 0, the counter becomes 1, and the state moves to ST_WRITING. If frame_size==1, that beat goes directly to ST_HANDOFF.
- ST_WRITING: in_ready=1. Each accepted beat is written at the counter address and the counter increments.
  - Accepting the beat at address frame_size-1 moves the state to ST_HANDOFF.
  - Early SOF (in_sof=1 at counter≠0): sof_errors increments (saturating); the beat is written to address 0; the counter becomes 1; stay in ST_WRITING; the partial frame is discarded.
- Write pipeline: registered, latency 1. wr_en/wr_address/wr_data/wr_bram_index are valid the cycle after acceptance. wr_en=0 on cycles with no accepted, writable beat.
- ST_HANDOFF: in_ready=0 (backpressure; no beats lost).
  - Issue start when reader_idle=1 && start_guard=0, but never in the same cycle as the last-beat wr_en (earliest: 1 cycle after it).
  - On start: reader_start=1 for exactly one cycle; reader_bram_index=wr_bram_index (the filled buffer); wr_bram_index toggles; frames_written increments (wraps); counter resets to 0; state moves to ST_WAIT_SOF.
- start_guard: set the cycle after reader_start and held 1 cycle. It masks the reader's one-cycle lag in dropping reader_idle, so two starts can never issue back-to-back.
- reader_idle=0 during ST_HANDOFF: wait indefinitely; in_ready stays 0.
- Ping-pong invariant: the writer never writes the buffer last handed to the reader until the reader has been seen idle after that handoff.
- in_sof on a beat while in_ready=0: not accepted; the source must hold it.

Test Plan:
- width=4, height=2, reader_idle=1; SOF + 8 beats data 1..8 → wr_en at addresses 0..7 in buffer 0 with data 1..8, each 1 cycle after acceptance; reader_start pulses once with reader_bram_index=0; wr_bram_index becomes 1; frames_written=1.
- Second frame with reader_idle=0 held for 20 cycles after the last beat → in_ready=0 and no reader_start for 20 cycles; reader_idle=1 → start with index 1 on the next eligible cycle; the third frame writes buffer 0.
- 3 beats with in_sof=0 before SOF → no wr_en for them; the SOF beat lands at address 0.
- SOF, 5 beats, then SOF again → sof_errors=1; the new SOF beat is written at address 0; handoff occurs only after 8 beats from the second SOF.
- Reset asserted at address 4 → all outputs return to reset values next cycle, with no reader_start; next SOF writes buffer 0, address 0.
- Random in_valid gaps, and reader_idle dropping 1 cycle after each start over 300 frames → no back-to-back starts, no data loss, frames_written=300, buffer indices alternate 0/1.
